shifter_seq: RTL and testbench



---
 rtl/shifter_seq.sv | 93 +++++++++
 tb/tb_shifter_seq.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/shifter_seq.sv
// Multi-cycle shifter: LSL/LSR/ASR/ROR, one bit position per clock.
// Define SHIFTER_SEQ_ROR_EN to build the rotate path; otherwise op=11 acts as LSR.
module shifter_seq #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [SHW-1:0]   shamt,
  input  logic [WIDTH-1:0] d_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d_out
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] w, w_nx, sh1, dout_nx;
  logic [SHW-1:0]   cnt, cnt_nx;
  logic [1:0]       op_r, op_nx;

  always_comb begin
    sh1 = w;
    unique case (op_r)
      2'b00: sh1 = {w[WIDTH-2:0], 1'b0};
      2'b01: sh1 = {1'b0, w[WIDTH-1:1]};
      2'b10: sh1 = {w[WIDTH-1], w[WIDTH-1:1]};
`ifdef SHIFTER_SEQ_ROR_EN
      2'b11: sh1 = {w[0], w[WIDTH-1:1]};
`else
      2'b11: sh1 = {1'b0, w[WIDTH-1:1]};
`endif
      default: sh1 = w;
    endcase
  end

  always_comb begin
    state_nx = state;
    w_nx     = w;
    cnt_nx   = cnt;
    op_nx    = op_r;
    dout_nx  = d_out;
    unique case (state)
      IDLE: begin
        if (start) begin
          w_nx     = d_in;
          cnt_nx   = shamt;
          op_nx    = op;
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt != '0) begin
          w_nx   = sh1;
          cnt_nx = cnt - SHW'(1);
        end else begin
          dout_nx  = w;
          state_nx = DONE;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      w     <= '0;
      cnt   <= '0;
      op_r  <= '0;
      d_out <= '0;
    end else begin
      state <= state_nx;
      w     <= w_nx;
      cnt   <= cnt_nx;
      op_r  <= op_nx;
      d_out <= dout_nx;
    end
  end

  // Flag outputs decode the state register only, so they carry no input path.
  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_shifter_seq.sv
// Bench for shifter_seq: directed cases plus random traffic
// checked every cycle against a cycle-count reference model.
module tb_shifter_seq;
  localparam int W  = 8;
  localparam int SW = $clog2(W);

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [1:0]    op;
  logic [SW-1:0] shamt;
  logic [W-1:0]  d_in;
  logic          busy;
  logic          done;
  logic [W-1:0]  d_out;

  always #5 clk = ~clk;

  shifter_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .shamt (shamt),
    .d_in  (d_in),
    .busy  (busy),
    .done  (done),
    .d_out (d_out)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic         m_busy = 1'b0;
  logic         m_done = 1'b0;
  logic [W-1:0] m_dout = '0;
  logic [W-1:0] m_res  = '0;
  int           m_end  = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d",
               name, act, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] ref_shift(input logic [W-1:0] d,
                                             input logic [1:0] o,
                                             input int s);
    logic signed [W-1:0] sd;
    logic [2*W-1:0]      dd;
    sd = d;
    dd = {d, d} >> s;
    case (o)
      2'd0:    return W'(d << s);
      2'd1:    return W'(d >> s);
      2'd2:    return W'(sd >>> s);
`ifdef SHIFTER_SEQ_ROR_EN
      default: return dd[W-1:0];
`else
      default: return W'(d >> s);
`endif
    endcase
  endfunction

  // Reference: a request finishes shamt+1 edges after capture, then one DONE cycle.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy = 1'b0;
      m_done = 1'b0;
      m_dout = '0;
    end else begin
      cyc++;
      if (m_done) begin
        m_done = 1'b0;
        m_busy = 1'b0;
      end else if (m_busy) begin
        if (cyc == m_end) begin
          m_done = 1'b1;
          m_dout = m_res;
        end
      end else if (start) begin
        m_busy = 1'b1;
        m_end  = cyc + int'(shamt) + 1;
        m_res  = ref_shift(d_in, op, int'(shamt));
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", 32'(busy), 32'(m_busy));
    chk("done", 32'(done), 32'(m_done));
    chk("d_out", 32'(d_out), 32'(m_dout));
  end

  task automatic wait_idle();
    for (int i = 0; i < 40 && busy; i++) @(negedge clk);
    chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic run_lit(input string name, input logic [W-1:0] d,
                         input logic [1:0] o, input int s,
                         input logic [W-1:0] exp);
    int kc, bc, dc;
    logic [W-1:0] got;
    wait_idle();
    start = 1'b1;
    d_in  = d;
    op    = o;
    shamt = SW'(s);
    @(negedge clk);
    start = 1'b0;
    d_in  = W'($urandom);
    kc    = cyc;
    bc    = 0;
    dc    = -1;
    got   = 'x;
    for (int i = 0; i < 40; i++) begin
      if (busy) bc++;
      if (done) begin
        dc  = cyc;
        got = d_out;
      end
      if (!busy) break;
      @(negedge clk);
    end
    chk({name, "_dout"}, 32'(got), 32'(exp));
    chk({name, "_lat"}, 32'(dc - kc), 32'(s + 1));
    chk({name, "_busy"}, 32'(bc), 32'(s + 2));
    chk({name, "_model"}, 32'(ref_shift(d, o, s)), 32'(exp));
  endtask

  initial begin
    int pulses;
    logic [W-1:0] got;
    reset = 1'b1;
    start = 1'b0;
    op    = '0;
    shamt = '0;
    d_in  = '0;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_dout", 32'(d_out), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    run_lit("asr1", 8'hAA, 2'd2, 1, 8'hD5);
    run_lit("asr2", 8'hAA, 2'd2, 2, 8'hEA);
    run_lit("lsr3", 8'h18, 2'd1, 3, 8'h03);
    run_lit("lsl7", 8'h81, 2'd0, 7, 8'h80);
`ifdef SHIFTER_SEQ_ROR_EN
    run_lit("ror1", 8'h81, 2'd3, 1, 8'hC0);
`else
    run_lit("ror1", 8'h81, 2'd3, 1, 8'h40);
`endif
    for (int o = 0; o < 4; o++) run_lit("sh0", 8'h5A, 2'(o), 0, 8'h5A);

    // A second start while shifting must be dropped.
    wait_idle();
    start = 1'b1; d_in = 8'hAA; op = 2'd2; shamt = 3'd5;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; d_in = 8'hFF; op = 2'd0; shamt = 3'd1;
    @(negedge clk);
    start = 1'b0;
    pulses = 0;
    got = '0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        pulses++;
        got = d_out;
      end
      @(negedge clk);
    end
    chk("ign_dout", 32'(got), 32'hFD);
    chk("ign_pulses", 32'(pulses), 32'd1);

    // Asynchronous abort mid-shift.
    wait_idle();
    start = 1'b1; d_in = 8'hAA; op = 2'd2; shamt = 3'd7;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_dout", 32'(d_out), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    run_lit("post_rst", 8'h80, 2'd2, 7, 8'hFF);

    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      #1;
      start = !m_done && ($urandom_range(0, 3) == 0);
      d_in  = W'($urandom);
      op    = 2'($urandom);
      shamt = SW'($urandom);
      reset = ($urandom_range(0, 99) == 0);
    end
    @(negedge clk);
    #1;
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    wait_idle();
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
